// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Feeds real-valued samples into a streaming FFT core in frames of a
//   run-time selectable length. A one-deep holding register decouples the
//   sample source from core back-pressure; samples arriving while the hold
//   register is occupied and not draining are dropped and flagged. The
//   number of frames handed to the core but not yet seen on its output is
//   tracked and input is throttled at MAX_INFLIGHT.
//
// Ports
//   clk, reset_n     clock, synchronous active-low reset
//   start, stop      run control pulses; continuous selects back-to-back frames
//   pts_cfg          requested frame length (power of two, 8..1024)
//   sample_in/valid  incoming real samples
//   sink_ready       core can accept input
//   source_eop       core finished emitting a frame
//   sink_*           core input stream (imag tied to 0)
//   fftpts           frame length latched at start
//   busy             not IDLE
//   frame_done       one-cycle pulse per source_eop
//   overrun          sticky dropped-sample flag
//   cfg_err          one-cycle pulse when start is rejected
module fft_frame_sequencer #(
  parameter int DATA_W       = 14,
  parameter int PTS_W        = 11,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [PTS_W-1:0]  pts_cfg,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              sink_ready,
  input  logic              source_eop,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [PTS_W-1:0]  fftpts,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              cfg_err
);

  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PTS_W-1:0] PTS_MIN = PTS_W'(8);
  localparam logic [PTS_W-1:0] PTS_MAX = PTS_W'(1024);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t             state;
  logic [PTS_W-1:0]   count;
  logic [INF_W-1:0]   inflight;
  logic               hold_v;
  logic [DATA_W-1:0]  hold_d;
  logic               stop_pending;

  logic transfer, is_last, pts_ok, inf_inc, inf_dec, keep_running;

  // Power of two within range: exactly one bit set and bounds respected.
  assign pts_ok = (pts_cfg >= PTS_MIN) && (pts_cfg <= PTS_MAX) &&
                  ((pts_cfg & (pts_cfg - PTS_W'(1))) == '0);

  assign is_last    = (count == fftpts - PTS_W'(1));
  assign sink_valid = hold_v && (state == STREAM) &&
                      (inflight < INF_W'(MAX_INFLIGHT));
  assign transfer   = sink_valid && sink_ready;
  assign sink_sop   = sink_valid && (count == '0);
  assign sink_eop   = sink_valid && is_last;
  assign sink_real  = hold_d;
  assign sink_imag  = '0;
  assign busy       = (state != IDLE);

  assign inf_inc = transfer && is_last;
  // An output end-of-frame with nothing outstanding is spurious; ignore it.
  assign inf_dec = source_eop && (inflight != '0);

  // A stop arriving with the last sample still ends the run at that frame.
  assign keep_running = continuous && !stop_pending && !stop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      inflight     <= '0;
      hold_v       <= 1'b0;
      hold_d       <= '0;
      stop_pending <= 1'b0;
      overrun      <= 1'b0;
      cfg_err      <= 1'b0;
      frame_done   <= 1'b0;
      fftpts       <= '0;
    end else begin
      cfg_err    <= 1'b0;
      frame_done <= source_eop;

      if (inf_inc && !inf_dec)
        inflight <= inflight + INF_W'(1);
      else if (!inf_inc && inf_dec)
        inflight <= inflight - INF_W'(1);

      case (state)
        IDLE: begin
          hold_v       <= 1'b0;
          stop_pending <= 1'b0;
          if (start) begin
            if (pts_ok) begin
              fftpts  <= pts_cfg;
              overrun <= 1'b0;
              count   <= '0;
              state   <= STREAM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        STREAM: begin
          if (stop)
            stop_pending <= 1'b1;

          // Hold register refills in the same cycle it drains.
          if (sample_valid && (!hold_v || transfer)) begin
            hold_v <= 1'b1;
            hold_d <= sample_in;
          end else begin
            if (transfer)
              hold_v <= 1'b0;
            if (sample_valid)
              overrun <= 1'b1;
          end

          if (transfer) begin
            if (is_last) begin
              count <= '0;
              if (!keep_running) begin
                // Anything captured behind the final sample is discarded.
                hold_v <= 1'b0;
                state  <= DRAIN;
              end
            end else begin
              count <= count + PTS_W'(1);
            end
          end
        end

        DRAIN: begin
          hold_v <= 1'b0;
          if (inflight == '0) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: start-acceptance vector table plus
// hand-written frame sequences; core-input samples are checked against a
// scoreboard queue filled as stimulus is driven.
module tb_fft_frame_sequencer;

  localparam int DATA_W = 14;
  localparam int PTS_W  = 11;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, stop, continuous;
  logic [PTS_W-1:0]  pts_cfg;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid, sink_ready, source_eop;
  logic              sink_valid, sink_sop, sink_eop;
  logic [DATA_W-1:0] sink_real, sink_imag;
  logic [PTS_W-1:0]  fftpts;
  logic              busy, frame_done, overrun, cfg_err;

  fft_frame_sequencer #(.DATA_W(DATA_W), .PTS_W(PTS_W), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .pts_cfg(pts_cfg), .sample_in(sample_in),
    .sample_valid(sample_valid), .sink_ready(sink_ready),
    .source_eop(source_eop), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .fftpts(fftpts), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] real_v;
    logic              sop;
    logic              eop;
  } exp_t;

  typedef struct {
    logic [PTS_W-1:0] pts;
    logic             acc;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d @%0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] p_real;
  logic              p_sop, p_eop;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'b0, sink_valid}, 32'd1);
        chk("stall_real", {18'b0, sink_real}, {18'b0, p_real});
        chk("stall_sop", {31'b0, sink_sop}, {31'b0, p_sop});
        chk("stall_eop", {31'b0, sink_eop}, {31'b0, p_eop});
      end
      if (sink_valid && sink_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer got=%0d want=none @%0t", sink_real, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("xfer_real", {18'b0, sink_real}, {18'b0, e.real_v});
          chk("xfer_sop", {31'b0, sink_sop}, {31'b0, e.sop});
          chk("xfer_eop", {31'b0, sink_eop}, {31'b0, e.eop});
          chk("xfer_imag", {18'b0, sink_imag}, 32'd0);
        end
      end
      stall_prev = sink_valid && !sink_ready;
      p_real     = sink_real;
      p_sop      = sink_sop;
      p_eop      = sink_eop;
    end
  end

  task automatic idle_inputs();
    start = 0; stop = 0; sample_valid = 0; source_eop = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic do_start(input logic [PTS_W-1:0] pts, input logic cont);
    pts_cfg = pts; continuous = cont; start = 1;
    tick();
    start = 0;
  endtask

  // Drive one sample for one cycle; push an expectation when it will reach the core.
  task automatic samp(input int v, input logic sop, input logic eop, input logic push);
    exp_t e;
    sample_valid = 1;
    sample_in    = DATA_W'(v);
    if (push) begin
      e.real_v = DATA_W'(v); e.sop = sop; e.eop = eop;
      exp_q.push_back(e);
    end
    tick();
    sample_valid = 0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic pulse_eop();
    source_eop = 1;
    tick();
    source_eop = 0;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{11'd8,    1'b1};
    tbl[1] = '{11'd12,   1'b0};
    tbl[2] = '{11'd1024, 1'b1};
    tbl[3] = '{11'd4,    1'b0};
    tbl[4] = '{11'd0,    1'b0};
    tbl[5] = '{11'd16,   1'b1};
    tbl[6] = '{11'd2047, 1'b0};
    tbl[7] = '{11'd512,  1'b1};

    sink_ready = 1; continuous = 0; pts_cfg = '0; sample_in = '0;
    do_reset();

    // Reset state
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, sink_valid}, 0);
    chk("rst_fftpts", {21'b0, fftpts}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);

    // Start acceptance table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      do_start(tbl[i].pts, 1'b0);
      chk("tbl_cfg_err", {31'b0, cfg_err}, {31'b0, !tbl[i].acc});
      chk("tbl_busy", {31'b0, busy}, {31'b0, tbl[i].acc});
      chk("tbl_fftpts", {21'b0, fftpts}, tbl[i].acc ? {21'b0, tbl[i].pts} : 32'd0);
      tick();
      chk("tbl_cfg_err_pulse", {31'b0, cfg_err}, 0);
    end

    // Single 8-point frame, then rejected start keeps fftpts
    do_reset();
    do_start(11'd8, 1'b0);
    for (int v = 1; v <= 8; v++) samp(v, v == 1, v == 8, 1'b1);
    wait_empty("f1_q");
    chk("f1_drain_valid", {31'b0, sink_valid}, 0);
    chk("f1_drain_busy", {31'b0, busy}, 1);
    pulse_eop();
    chk("f1_frame_done", {31'b0, frame_done}, 1);
    tick();
    chk("f1_idle", {31'b0, busy}, 0);
    chk("f1_fd_pulse", {31'b0, frame_done}, 0);
    do_start(11'd12, 1'b0);
    chk("bad_cfg_err", {31'b0, cfg_err}, 1);
    chk("bad_busy", {31'b0, busy}, 0);
    chk("bad_fftpts", {21'b0, fftpts}, 8);
    pulse_eop();
    chk("spurious_fd", {31'b0, frame_done}, 1);
    chk("spurious_busy", {31'b0, busy}, 0);

    // Back-pressure: ready low 3 cycles with a sample each cycle
    do_start(11'd8, 1'b0);
    for (int v = 1; v <= 3; v++) samp(v, v == 1, 1'b0, 1'b1);
    tick();                       // hold drains, empty at stall start
    sink_ready = 0;
    samp(4, 0, 0, 1'b1);
    chk("ovr_first", {31'b0, overrun}, 0);
    samp(5, 0, 0, 1'b0);
    chk("ovr_second", {31'b0, overrun}, 1);
    samp(6, 0, 0, 1'b0);
    sink_ready = 1;
    for (int v = 7; v <= 10; v++) samp(v, 1'b0, v == 10, 1'b1);
    wait_empty("stall_q");
    pulse_eop();
    tick();
    chk("stall_idle", {31'b0, busy}, 0);
    chk("ovr_sticky", {31'b0, overrun}, 1);

    // Continuous: throttled at two outstanding frames, stop at sample 3
    do_start(11'd8, 1'b1);
    chk("cont_ovr_clr", {31'b0, overrun}, 0);
    for (int v = 1; v <= 16; v++) samp(v, v == 1 || v == 9, v == 8 || v == 16, 1'b1);
    samp(17, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("cont_throttle", {31'b0, sink_valid}, 0);
      tick();
    end
    chk("cont_q_held", exp_q.size(), 1);
    pulse_eop();
    chk("cont_fd", {31'b0, frame_done}, 1);
    samp(18, 0, 0, 1'b1);
    stop = 1;
    samp(19, 0, 0, 1'b1);
    stop = 0;
    for (int v = 20; v <= 24; v++) samp(v, 1'b0, v == 24, 1'b1);
    wait_empty("cont_q");
    samp(99, 0, 0, 1'b0);         // ignored in DRAIN
    samp(98, 0, 0, 1'b0);
    chk("drain_no_ovr", {31'b0, overrun}, 0);
    chk("drain_valid", {31'b0, sink_valid}, 0);
    chk("drain_busy", {31'b0, busy}, 1);
    pulse_eop();
    tick();
    chk("drain_wait", {31'b0, busy}, 1);
    pulse_eop();
    chk("drain_last", {31'b0, busy}, 1);
    tick();
    chk("stop_idle", {31'b0, busy}, 0);

    // Reset mid-frame at sample 5
    do_start(11'd8, 1'b0);
    for (int v = 1; v <= 3; v++) samp(v, v == 1, 1'b0, 1'b1);
    samp(4, 0, 0, 1'b0);
    reset_n = 0;
    samp(5, 0, 0, 1'b0);
    reset_n = 1;
    chk("mr_valid", {31'b0, sink_valid}, 0);
    chk("mr_sop", {31'b0, sink_sop}, 0);
    chk("mr_eop", {31'b0, sink_eop}, 0);
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_fftpts", {21'b0, fftpts}, 0);
    chk("mr_real", {18'b0, sink_real}, 0);
    chk("mr_q", exp_q.size(), 0);
    do_start(11'd16, 1'b0);
    chk("mr16_fftpts", {21'b0, fftpts}, 16);
    for (int v = 1; v <= 16; v++) samp(v + 100, v == 1, v == 16, 1'b1);
    wait_empty("mr16_q");
    pulse_eop();
    tick();
    chk("mr16_idle", {31'b0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
